// File: rtl/if_id_stall_ctrl.sv
// rtl/if_id_stall_ctrl.sv - IF/ID pipeline register with stall/flush control and stall watchdog
// Optional performance counters enabled by defining IF_ID_PERF_COUNTERS_EN.
module if_id_stall_ctrl #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int                MAX_STALL = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Stall,
  input  logic              BranchTaken_D,
  input  logic [DATA_W-1:0] Instr_F,
  input  logic [DATA_W-1:0] PCPlus4_F,
  output logic [DATA_W-1:0] Instr_D,
  output logic [DATA_W-1:0] PCPlus4_D,
  output logic              PCWriteEN,
  output logic              FlushE,
  output logic [1:0]        State,
  output logic              StallErr
`ifdef IF_ID_PERF_COUNTERS_EN
  ,
  output logic [31:0]       StallCycles,
  output logic [31:0]       FlushCycles
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic              s_eff;
  logic              f_eff;
  logic [DATA_W-1:0] instr_d_q, instr_d_d;
  logic [DATA_W-1:0] pcplus4_d_q, pcplus4_d_d;
  logic [1:0]        state_q, state_d;
  logic [3:0]        stall_cnt_q, stall_cnt_d;
  logic              stall_err_q, stall_err_d;

  // Stall wins over a branch: the branch operands are not resolved yet.
  assign s_eff = Stall & ~RESET;
  assign f_eff = BranchTaken_D & ~Stall & ~RESET;

  assign PCWriteEN = ~s_eff;
  assign FlushE    = s_eff;

  always_comb begin
    instr_d_d   = instr_d_q;
    pcplus4_d_d = pcplus4_d_q;
    state_d     = ST_RUN;
    stall_cnt_d = 4'd0;
    stall_err_d = stall_err_q;
    if (s_eff) begin
      state_d     = ST_STALL;
      stall_cnt_d = (stall_cnt_q == 4'hF) ? stall_cnt_q : stall_cnt_q + 4'd1;
      if (stall_cnt_q >= 4'(MAX_STALL)) stall_err_d = 1'b1;
    end else if (f_eff) begin
      state_d     = ST_FLUSH;
      instr_d_d   = NOP_INSTR;
      pcplus4_d_d = PCPlus4_F;
    end else begin
      instr_d_d   = Instr_F;
      pcplus4_d_d = PCPlus4_F;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      instr_d_q   <= NOP_INSTR;
      pcplus4_d_q <= '0;
      state_q     <= ST_RUN;
      stall_cnt_q <= 4'd0;
      stall_err_q <= 1'b0;
    end else begin
      instr_d_q   <= instr_d_d;
      pcplus4_d_q <= pcplus4_d_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign Instr_D   = instr_d_q;
  assign PCPlus4_D = pcplus4_d_q;
  assign State     = state_q;
  assign StallErr  = stall_err_q;

`ifdef IF_ID_PERF_COUNTERS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_cycles_q, flush_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, s_eff};
    flush_cycles_d = flush_cycles_q + {31'd0, f_eff};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// tb/tb_if_id_stall_ctrl.sv - randomized self-checking bench for if_id_stall_ctrl
module tb_if_id_stall_ctrl;

  localparam int MAX_STALL = 4;

  logic        CLK = 1'b0;
  logic        RESET, Stall, BranchTaken_D;
  logic [31:0] Instr_F, PCPlus4_F;
  logic [31:0] Instr_D, PCPlus4_D;
  logic        PCWriteEN, FlushE, StallErr;
  logic [1:0]  State;
`ifdef IF_ID_PERF_COUNTERS_EN
  logic [31:0] StallCycles, FlushCycles;
`endif

  always #5 CLK = ~CLK;

  if_id_stall_ctrl #(.DATA_W(32), .NOP_INSTR(32'h0), .MAX_STALL(MAX_STALL)) dut (
    .CLK(CLK), .RESET(RESET), .Stall(Stall), .BranchTaken_D(BranchTaken_D),
    .Instr_F(Instr_F), .PCPlus4_F(PCPlus4_F), .Instr_D(Instr_D), .PCPlus4_D(PCPlus4_D),
    .PCWriteEN(PCWriteEN), .FlushE(FlushE), .State(State), .StallErr(StallErr)
`ifdef IF_ID_PERF_COUNTERS_EN
    , .StallCycles(StallCycles), .FlushCycles(FlushCycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: what the IF/ID stage should hold, in plain terms.
  logic [31:0] m_instr, m_pc;
  int          m_state, m_run, m_stall_tot, m_flush_tot;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit stl, input bit br,
                      input logic [31:0] ins, input logic [31:0] pc);
    bit s, f;
    @(negedge CLK);
    RESET = rst; Stall = stl; BranchTaken_D = br; Instr_F = ins; PCPlus4_F = pc;
    s = stl && !rst;
    f = br && !stl && !rst;
    #1;
    chk("pcwe", {31'd0, PCWriteEN}, {31'd0, !s});
    chk("flushe", {31'd0, FlushE}, {31'd0, s});
    @(posedge CLK);
    if (rst) begin
      m_instr = 32'h0; m_pc = 32'h0; m_state = 0; m_run = 0; m_err = 0;
      m_stall_tot = 0; m_flush_tot = 0;
    end else if (s) begin
      m_state = 1;
      m_run++;
      if (m_run > MAX_STALL) m_err = 1;
      m_stall_tot++;
    end else if (f) begin
      m_instr = 32'h0; m_pc = pc; m_state = 2; m_run = 0;
      m_flush_tot++;
    end else begin
      m_instr = ins; m_pc = pc; m_state = 0; m_run = 0;
    end
    #1;
    chk("instr_d", Instr_D, m_instr);
    chk("pcplus4_d", PCPlus4_D, m_pc);
    chk("state", {30'd0, State}, m_state[31:0]);
    chk("stallerr", {31'd0, StallErr}, {31'd0, m_err});
`ifdef IF_ID_PERF_COUNTERS_EN
    chk("stallcycles", StallCycles, m_stall_tot[31:0]);
    chk("flushcycles", FlushCycles, m_flush_tot[31:0]);
`endif
  endtask

  initial begin
    int burst;
    bit stl, br, rst;
    RESET = 1'b1; Stall = 1'b0; BranchTaken_D = 1'b0; Instr_F = '0; PCPlus4_F = '0;
    m_instr = '0; m_pc = '0; m_state = 0; m_run = 0; m_err = 0;
    m_stall_tot = 0; m_flush_tot = 0;

    // Directed sequence from the plan.
    step(1, 1, 0, 32'h2002_0005, 32'h4);
    step(1, 0, 0, 32'h2002_0005, 32'h4);
    step(0, 0, 0, 32'h8C43_0004, 32'h8);
    step(0, 1, 0, 32'h0064_2020, 32'hC);
    step(0, 0, 0, 32'h0064_2020, 32'hC);
    step(0, 0, 1, 32'h1234_5678, 32'h10);
    step(0, 1, 1, 32'hAAAA_5555, 32'h14);
    step(0, 0, 1, 32'hAAAA_5555, 32'h14);
    step(0, 0, 1, 32'hBBBB_0000, 32'h18);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 32'hCCCC_0000, 32'h1C);
    chk("wd_set", {31'd0, StallErr}, 32'd1);
    step(0, 0, 0, 32'hDDDD_0000, 32'h20);
    chk("wd_sticky", {31'd0, StallErr}, 32'd1);
    step(1, 0, 0, 32'hDDDD_0000, 32'h20);
    chk("wd_clear", {31'd0, StallErr}, 32'd0);

    // Randomized traffic with stall bursts of varying length.
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 8);
      stl = (burst > 0) || ($urandom_range(0, 5) == 0);
      if (burst > 0) burst--;
      br  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step(rst, stl, br, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stall_ctrl.md
Name: if_id_stall_ctrl

Overview:
- Consumer end of the pipeline stall/flush interface: takes the combinational Stall request from the hazard detector and the branch-resolved signal from the Decode stage.
- Owns the IF/ID pipeline register and drives PC write-enable and the ID/EX bubble.
- Tracks consecutive stall cycles with a watchdog.
- Sits between the Fetch stage (PC register, instruction memory) and the Decode stage.

Parameters:
- DATA_W, 32, width of the instruction and PC+4 fields
- NOP_INSTR, 32'h0000_0000, encoding loaded into IF/ID on flush or reset (MIPS sll $0,$0,0)
- MAX_STALL, 4, consecutive stall cycles allowed before StallErr is raised (range 1..15)

Ports:
- CLK  in  1  pipeline clock, rising edge
- RESET  in  1  synchronous, active-high reset
- Stall  in  1  hazard request: hold PC and IF/ID, bubble ID/EX
- BranchTaken_D  in  1  branch in D resolved taken; squash the instruction in F
- Instr_F  in  DATA_W  instruction fetched this cycle
- PCPlus4_F  in  DATA_W  PC+4 of the fetched instruction
- Instr_D  out  DATA_W  IF/ID registered instruction
- PCPlus4_D  out  DATA_W  IF/ID registered PC+4
- PCWriteEN  out  1  PC register load enable (combinational)
- FlushE  out  1  clear ID/EX control fields this cycle (combinational)
- State  out  2  current controller state: 0 RUN, 1 STALL, 2 FLUSH
- StallErr  out  1  sticky: stall exceeded MAX_STALL

Behaviour:
- Clock/reset (decided): single clock CLK; RESET is synchronous and active-high.
- Reset values:
  - Instr_D = NOP_INSTR
  - PCPlus4_D = 0
  - State = RUN
  - StallErr = 0
  - stall run counter = 0
- Reset overrides all other inputs in the same edge.
- Effective stall: S = Stall & ~RESET.
- Effective flush: F = BranchTaken_D & ~Stall & ~RESET.
  - Stall has priority: a branch waiting on operands is not yet resolved, so BranchTaken_D is ignored while Stall = 1.
- Combinational outputs:
  - PCWriteEN = ~S
  - FlushE = S (one bubble per stall cycle)
- IF/ID register, per edge, in priority order:
  - RESET: load reset values.
  - S: hold Instr_D and PCPlus4_D unchanged.
  - F: Instr_D <= NOP_INSTR, PCPlus4_D <= PCPlus4_F (PC kept for debug).
  - Otherwise: Instr_D <= Instr_F, PCPlus4_D <= PCPlus4_F.
- Latency: one cycle F to D when running; zero-cycle response on PCWriteEN and FlushE.
- State machine (registered, next state evaluated from S and F at each edge):
  - RUN -> STALL if S; RUN -> FLUSH if F; otherwise stay in RUN.
  - STALL -> STALL if S; -> FLUSH if F; otherwise -> RUN.
  - FLUSH -> STALL if S; -> FLUSH if F (back-to-back branches); otherwise -> RUN.
  - State reflects the action taken at the previous edge.
- Stall run counter (4 bits):
  - Increments on each edge with S; saturates at 15.
  - Clears on any edge without S.
- StallErr:
  - Set on the edge where the counter would reach MAX_STALL+1, i.e. the (MAX_STALL+1)th consecutive stall.
  - Cleared only by RESET.
  - Stall handling continues normally after StallErr is set.
- Stall and BranchTaken_D together: treated as a stall; the branch is re-evaluated the next cycle.

Optional Feature:
- Macro: IF_ID_PERF_COUNTERS_EN
- Defined:
  - Adds outputs StallCycles[31:0] and FlushCycles[31:0].
  - StallCycles increments on each edge with S; FlushCycles increments on each edge with F.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RESET 2 cycles with Instr_F=32'h2002_0005 -> Instr_D=0, PCPlus4_D=0, State=0, PCWriteEN=1, StallErr=0.
- Run: Instr_F=32'h8C43_0004, PCPlus4_F=32'h0000_0008, no Stall -> next cycle Instr_D=32'h8C43_0004, PCPlus4_D=8, State=0.
- Load-use stall: Stall=1 for 1 cycle -> PCWriteEN=0 and FlushE=1 that cycle; Instr_D held; State=1; next cycle resumes and State=0.
- Branch flush: BranchTaken_D=1, Stall=0, PCPlus4_F=32'h10 -> Instr_D=0, PCPlus4_D=32'h10, State=2.
- Priority: Stall=1 and BranchTaken_D=1 together -> Instr_D held (no NOP), State=1; then Stall=0 with BranchTaken_D=1 -> flush, State=2.
- Watchdog: MAX_STALL=4, Stall=1 for 5 cycles -> StallErr=0 after 4 edges, 1 after the 5th edge, stays 1 after Stall drops; clears only on RESET.
  - With IF_ID_PERF_COUNTERS_EN defined: StallCycles=5.
